parallax_scroll_sequencer: RTL and testbench

Per-frame scroll controller for the five-layer parallax checker datapath that sits behind the hvsync generator. On every vsync rising edge it advances one fixed-point scroll accumulator per layer and axis through a single shared adder, then commits all offsets at once, so a frame never sees a half-updated set. Per-layer speeds are writable through a valid/ready config port; pause and single-step support frame-accurate debug.

---
 rtl/parallax_scroll_sequencer.sv | 157 +++++++++++++++
 tb/tb_parallax_scroll_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallax_scroll_sequencer.sv
// Per-frame scroll controller: on each vsync rise, walks every layer/axis accumulator
// through one shared adder, then commits all offsets together so a frame never sees a partial set.
module parallax_scroll_sequencer #(
  parameter int NUM_LAYERS = 5,
  parameter int OFS_W      = 10,
  parameter int SPD_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vsync,
  input  logic                        pause,
  input  logic                        step,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [2:0]                  cfg_layer,
  input  logic                        cfg_axis,
  input  logic [SPD_W-1:0]            cfg_speed,
  output logic [NUM_LAYERS*OFS_W-1:0] ofs_x,
  output logic [NUM_LAYERS*OFS_W-1:0] ofs_y,
  output logic [9:0]                  frame_cnt,
  output logic                        busy,
  output logic                        overrun,
  output logic                        cfg_err
);
  localparam int ACC_W = OFS_W + 2;
  localparam int K_W   = $clog2(2 * NUM_LAYERS);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   k;
  logic             vsync_d, rise, adv, step_pend, cfg_accept;
  logic [SPD_W-1:0] spd_x [NUM_LAYERS];
  logic [SPD_W-1:0] spd_y [NUM_LAYERS];
  logic [ACC_W-1:0] acc_x [NUM_LAYERS];
  logic [ACC_W-1:0] acc_y [NUM_LAYERS];
  logic [ACC_W-1:0] sel_acc, sum;
  logic [SPD_W-1:0] sel_spd;

  function automatic logic [SPD_W-1:0] reset_speed(input int layer, input logic axis);
    int v;
    v = 1;
    case (layer)
      0: v = axis ? 8 : 64;
      1: v = axis ? 6 : 28;
      2: v = axis ? 2 : 16;
      3: v = axis ? 1 : 8;
      4: v = axis ? 1 : 2;
      default: v = 1;
    endcase
    return SPD_W'(v);
  endfunction

  // Quarter-pixel accumulation wraps modulo 2^ACC_W; speed is zero-extended.
  function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                input logic [SPD_W-1:0] s);
    return a + ACC_W'(s);
  endfunction

  assign rise       = vsync & ~vsync_d;
  assign busy       = (state != IDLE);
  assign cfg_ready  = (state == IDLE) & ~rise;
  assign cfg_accept = cfg_valid & cfg_ready;

  always_comb begin
    sel_acc = '0;
    sel_spd = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (k == K_W'(2 * i)) begin
        sel_acc = acc_x[i];
        sel_spd = spd_x[i];
      end
      if (k == K_W'(2 * i + 1)) begin
        sel_acc = acc_y[i];
        sel_spd = spd_y[i];
      end
    end
    sum = wrap_add(sel_acc, adv ? sel_spd : '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = UPDATE;
      UPDATE:  if (k == K_W'(2 * NUM_LAYERS - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      vsync_d   <= 1'b0;
      adv       <= 1'b0;
      step_pend <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_d <= vsync;
      if (state == IDLE && rise) begin
        k   <= '0;
        adv <= ~pause | step_pend;
      end else if (state == UPDATE) begin
        k <= k + 1'b1;
      end
      if (rise && state != IDLE) overrun <= 1'b1;
      if (cfg_accept && int'(cfg_layer) >= NUM_LAYERS) cfg_err <= 1'b1;
      if (state == COMMIT && adv) frame_cnt <= frame_cnt + 1'b1;
      // A step arriving during an advancing commit requests a further frame.
      if (!pause) step_pend <= 1'b0;
      else if (step) step_pend <= 1'b1;
      else if (state == COMMIT && adv) step_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        spd_x[i] <= reset_speed(i, 1'b0);
        spd_y[i] <= reset_speed(i, 1'b1);
      end
    end else if (cfg_accept) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (int'(cfg_layer) == i) begin
          if (cfg_axis) spd_y[i] <= cfg_speed;
          else          spd_x[i] <= cfg_speed;
        end
      end
    end
  end

  // UPDATE writes one accumulator per cycle; COMMIT copies all integer parts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_x <= '0;
      ofs_y <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (state == UPDATE && k == K_W'(2 * i))     acc_x[i] <= sum;
        if (state == UPDATE && k == K_W'(2 * i + 1)) acc_y[i] <= sum;
        if (state == COMMIT) begin
          ofs_x[i*OFS_W +: OFS_W] <= acc_x[i][ACC_W-1:2];
          ofs_y[i*OFS_W +: OFS_W] <= acc_y[i][ACC_W-1:2];
        end
      end
    end
  end

endmodule

// File: tb/tb_parallax_scroll_sequencer.sv
// Scoreboard bench for parallax_scroll_sequencer: a reference model pushes expected
// offsets per frame; a monitor pops and compares when busy falls after COMMIT.
module tb_parallax_scroll_sequencer;
  localparam int N  = 5;
  localparam int OW = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          pause = 1'b0;
  logic          step = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_axis = 1'b0;
  logic [2:0]    cfg_layer = 3'd0;
  logic [SW-1:0] cfg_speed = '0;
  logic          cfg_ready, busy, overrun, cfg_err;
  logic [N*OW-1:0] ofs_x, ofs_y;
  logic [9:0]    frame_cnt;

  parallax_scroll_sequencer #(.NUM_LAYERS(N), .OFS_W(OW), .SPD_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .step(step),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_axis(cfg_axis), .cfg_speed(cfg_speed), .ofs_x(ofs_x), .ofs_y(ofs_y),
    .frame_cnt(frame_cnt), .busy(busy), .overrun(overrun), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [N*OW-1:0] x;
    logic [N*OW-1:0] y;
    logic [9:0]      fc;
  } exp_t;

  exp_t sb[$];

  int          m_spd_x[N];
  int          m_spd_y[N];
  logic [11:0] m_acc_x[N];
  logic [11:0] m_acc_y[N];
  int          m_fc;

  function automatic void model_reset();
    int rx[N] = '{64, 28, 16, 8, 2};
    int ry[N] = '{8, 6, 2, 1, 1};
    for (int i = 0; i < N; i++) begin
      m_spd_x[i] = rx[i];
      m_spd_y[i] = ry[i];
      m_acc_x[i] = '0;
      m_acc_y[i] = '0;
    end
    m_fc = 0;
  endfunction

  function automatic exp_t model_frame(input bit adv);
    exp_t e;
    if (adv) begin
      for (int i = 0; i < N; i++) begin
        m_acc_x[i] = m_acc_x[i] + 12'(m_spd_x[i]);
        m_acc_y[i] = m_acc_y[i] + 12'(m_spd_y[i]);
      end
      m_fc = (m_fc + 1) % 1024;
    end
    e.x = '0;
    e.y = '0;
    for (int i = 0; i < N; i++) begin
      e.x[i*OW +: OW] = m_acc_x[i][11:2];
      e.y[i*OW +: OW] = m_acc_y[i][11:2];
    end
    e.fc = 10'(m_fc);
    return e;
  endfunction

  // Monitor: count busy cycles, confirm outputs hold mid-update, compare at commit.
  logic          busy_prev = 1'b0;
  int            bcnt = 0;
  logic [N*OW-1:0] hold_x, hold_y;
  exp_t          got;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        hold_x = ofs_x;
        hold_y = ofs_y;
      end
      if (busy) begin
        bcnt++;
        if (bcnt == 6) begin
          check_val("hold_ofs_x", ofs_x, hold_x);
          check_val("hold_ofs_y", ofs_y, hold_y);
          check_val("cfg_ready_busy", cfg_ready, 0);
        end
      end
      if (!busy && busy_prev) begin
        if (sb.size() == 0) begin
          check_val("unexpected_commit", 1, 0);
        end else begin
          got = sb.pop_front();
          check_val("ofs_x", ofs_x, got.x);
          check_val("ofs_y", ofs_y, got.y);
          check_val("frame_cnt", frame_cnt, got.fc);
        end
        check_val("busy_cycles", bcnt, 11);
        bcnt = 0;
      end
      busy_prev = busy;
    end
  end

  // Called just after a falling edge; returns just after a falling edge once committed.
  task automatic run_frame(input bit adv, input bit extra_rise);
    sb.push_back(model_frame(adv));
    vsync = 1'b1;
    #1 check_val("cfg_ready_rise", cfg_ready, 0);
    @(negedge clk);
    vsync = 1'b0;
    if (extra_rise) begin
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check_val("frame_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic first_frame_checks(input string pfx);
    check_val({pfx, "_x0"}, ofs_x[0*OW +: OW], 16);
    check_val({pfx, "_x1"}, ofs_x[1*OW +: OW], 7);
    check_val({pfx, "_x4"}, ofs_x[4*OW +: OW], 0);
    check_val({pfx, "_y0"}, ofs_y[0*OW +: OW], 2);
    check_val({pfx, "_y1"}, ofs_y[1*OW +: OW], 1);
    check_val({pfx, "_fc"}, frame_cnt, 1);
  endtask

  task automatic reset_checks(input string pfx);
    check_val({pfx, "_ofs_x"}, ofs_x, 0);
    check_val({pfx, "_ofs_y"}, ofs_y, 0);
    check_val({pfx, "_fc"}, frame_cnt, 0);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_overrun"}, overrun, 0);
    check_val({pfx, "_cfg_err"}, cfg_err, 0);
    check_val({pfx, "_cfg_ready"}, cfg_ready, 1);
  endtask

  int          fc_saved;
  logic [OW-1:0] old_x2;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1 reset_checks("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    run_frame(1'b1, 1'b0);
    first_frame_checks("first");

    repeat (63) run_frame(1'b1, 1'b0);
    check_val("wrap_x0", ofs_x[0*OW +: OW], 0);
    check_val("f64_x4", ofs_x[4*OW +: OW], 32);
    check_val("f64_y4", ofs_y[4*OW +: OW], 16);
    check_val("f64_fc", frame_cnt, 64);

    // Speed write in IDLE takes effect on the next frame.
    cfg_valid = 1'b1; cfg_layer = 3'd2; cfg_axis = 1'b0; cfg_speed = 8'd40;
    #1 check_val("cfg_ready_idle", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    m_spd_x[2] = 40;
    old_x2 = ofs_x[2*OW +: OW];
    run_frame(1'b1, 1'b0);
    check_val("x2_delta", 10'(ofs_x[2*OW +: OW] - old_x2), 10);

    // Write held across a frame is accepted only after COMMIT.
    cfg_valid = 1'b1; cfg_layer = 3'd3; cfg_axis = 1'b1; cfg_speed = 8'd12;
    run_frame(1'b1, 1'b0);
    check_val("cfg_ready_after", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    m_spd_y[3] = 12;
    run_frame(1'b1, 1'b0);

    // Pause freezes; one step yields exactly one frame.
    fc_saved = int'(frame_cnt);
    pause = 1'b1;
    repeat (3) run_frame(1'b0, 1'b0);
    check_val("pause_fc", frame_cnt, 10'(fc_saved));
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);
    check_val("step_fc", frame_cnt, 10'(fc_saved + 1));
    pause = 1'b0;

    // Second rise during UPDATE.
    check_val("overrun_pre", overrun, 0);
    run_frame(1'b1, 1'b1);
    check_val("overrun_set", overrun, 1);
    fc_saved = int'(frame_cnt);
    repeat (20) @(negedge clk);
    #1;
    check_val("overrun_idle", busy, 0);
    check_val("overrun_fc", frame_cnt, 10'(fc_saved));

    // Out-of-range layer write is dropped.
    cfg_valid = 1'b1; cfg_layer = 3'd6; cfg_axis = 1'b0; cfg_speed = 8'd200;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 check_val("cfg_err_set", cfg_err, 1);
    run_frame(1'b1, 1'b0);

    // Asynchronous reset just before k = 4.
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
    run_frame(1'b1, 1'b0);
    first_frame_checks("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
